// File: rtl/fft_seq_pkg.sv
// Shared definitions for the FFT bar sequencer: FSM state encoding,
// default geometry and address-field widths.
package fft_seq_pkg;

  localparam int NUM_BARS_DEFAULT  = 64;
  localparam int BAR_MAX_DEFAULT   = 100;
  localparam int LIN_SHIFT_DEFAULT = 9;

  localparam int MAG_W  = 16;
  localparam int BAR_W  = 7;
  localparam int IDX_W  = 6;
  localparam int CH_W   = 1;
  localparam int ADDR_W = CH_W + IDX_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_CONVERT   = 3'd3,
    S_START     = 3'd4,
    S_WAIT_END  = 3'd5,
    S_NEXT      = 3'd6
  } seq_state_e;

endpackage

// File: rtl/bar_height_conv.sv
// Magnitude-to-bar-height mapping (purely combinational).
// Build option FFT_SEQ_LOG_SCALE_EN selects the log-like mapping
// (8*msb_index + next three bits); otherwise a linear shift is used.
module bar_height_conv
  import fft_seq_pkg::*;
#(
  parameter int BAR_MAX   = BAR_MAX_DEFAULT,
  parameter int LIN_SHIFT = LIN_SHIFT_DEFAULT
) (
  input  logic [MAG_W-1:0] mag_i,
  output logic [BAR_W-1:0] height_o
);

`ifdef FFT_SEQ_LOG_SCALE_EN
  logic [3:0]       msb;
  logic [MAG_W-1:0] norm;
  logic [7:0]       raw;

  // Locate the leading one, left-align it and take the three bits below it.
  always_comb begin
    msb = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (mag_i[i]) msb = 4'(i);
    end
    norm = mag_i << (4'd15 - msb);
    raw  = {1'b0, msb, 3'b000} + {5'b00000, norm[14:12]};
    if (mag_i == '0) begin
      height_o = '0;
    end else if (raw > 8'(BAR_MAX)) begin
      height_o = BAR_W'(BAR_MAX);
    end else begin
      height_o = raw[BAR_W-1:0];
    end
  end
`else
  logic [MAG_W-1:0] shifted;

  // Clamp at full 16-bit width so large magnitudes cannot wrap when narrowed.
  always_comb begin
    shifted = mag_i >> LIN_SHIFT;
    if (shifted > MAG_W'(BAR_MAX)) begin
      height_o = BAR_W'(BAR_MAX);
    end else begin
      height_o = shifted[BAR_W-1:0];
    end
  end
`endif

endmodule

// File: rtl/fft_bar_sequencer.sv
// Walks the stereo magnitude buffer (L bars then R bars), converts each
// magnitude to a bar height and hands it to the spectrum writer with a
// Start/End handshake. Build option: FFT_SEQ_LOG_SCALE_EN (log mapping).
// Handshake: Start is a one-cycle request with Bar valid from Start until
// the writer's one-cycle End; End is only honoured while waiting for it.
module fft_bar_sequencer
  import fft_seq_pkg::*;
#(
  parameter int NUM_BARS  = NUM_BARS_DEFAULT,
  parameter int BAR_MAX   = BAR_MAX_DEFAULT,
  parameter int LIN_SHIFT = LIN_SHIFT_DEFAULT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              FrameStart,
  input  logic              DrawTopEn,
  output logic              RdEn,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [MAG_W-1:0]  RdData,
  output logic              Start,
  output logic [BAR_W-1:0]  Bar,
  output logic              DrawTop,
  output logic              LRChange,
  output logic              NewFrame,
  input  logic              End,
  output logic              Active,
  output logic              FrameDone,
  output seq_state_e        StateDbg
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BARS - 1);

  seq_state_e        state_q, state_d;
  logic              chan_q, chan_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [MAG_W-1:0]  data_q;
  logic [BAR_W-1:0]  bar_q;
  logic              draw_top_q;
  logic [BAR_W-1:0]  height;

  bar_height_conv #(
    .BAR_MAX  (BAR_MAX),
    .LIN_SHIFT(LIN_SHIFT)
  ) u_conv (
    .mag_i   (data_q),
    .height_o(height)
  );

  // State, channel and bar-index registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      chan_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: one pass per bar, L channel first, then R.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (FrameStart) begin
          state_d = S_READ;
          chan_d  = 1'b0;
          idx_d   = '0;
        end
      end
      S_READ:      state_d = S_WAIT_DATA;
      S_WAIT_DATA: state_d = S_CONVERT;
      S_CONVERT:   state_d = S_START;
      S_START:     state_d = S_WAIT_END;
      S_WAIT_END: begin
        if (End) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_READ;
        end else if (!chan_q) begin
          idx_d   = '0;
          chan_d  = 1'b1;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath captures: magnitude, converted height, peak-marker enable.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      data_q     <= '0;
      bar_q      <= '0;
      draw_top_q <= 1'b0;
    end else begin
      if (state_q == S_WAIT_DATA) data_q <= RdData;
      if (state_q == S_CONVERT) bar_q <= height;
      if (state_q == S_IDLE && FrameStart) draw_top_q <= DrawTopEn;
    end
  end

  // Output decode from the current state.
  always_comb begin
    RdEn      = (state_q == S_READ);
    RdAddr    = (state_q == S_READ) ? {chan_q, idx_q} : '0;
    Start     = (state_q == S_START);
    NewFrame  = (state_q == S_READ) && !chan_q && (idx_q == '0);
    LRChange  = (state_q == S_NEXT) && (idx_q == LAST_IDX) && !chan_q;
    FrameDone = (state_q == S_NEXT) && (idx_q == LAST_IDX) && chan_q;
    Active    = (state_q != S_IDLE);
    Bar       = bar_q;
    DrawTop   = draw_top_q;
    StateDbg  = state_q;
  end

endmodule

// File: tb/tb_fft_bar_sequencer.sv
// Bench for fft_bar_sequencer: bench-side magnitude memory and writer model,
// a scoreboard of expected read addresses / bar heights, and literal pins.
module tb_fft_bar_sequencer;
  import fft_seq_pkg::*;

  localparam int NB      = 64;
  localparam int END_DLY = 10;

  // ---------------- clock / reset ----------------
  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              FrameStart = 1'b0;
  logic              DrawTopEn = 1'b0;
  logic              End = 1'b0;
  logic [15:0]       RdData = 16'h5A5A;
  logic              RdEn, Start, DrawTop, LRChange, NewFrame, Active, FrameDone;
  logic [6:0]        RdAddr, Bar;
  seq_state_e        StateDbg;

  always #5 Clock = ~Clock;

  fft_bar_sequencer dut (
    .Clock(Clock), .Reset(Reset), .FrameStart(FrameStart), .DrawTopEn(DrawTopEn),
    .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData), .Start(Start), .Bar(Bar),
    .DrawTop(DrawTop), .LRChange(LRChange), .NewFrame(NewFrame), .End(End),
    .Active(Active), .FrameDone(FrameDone), .StateDbg(StateDbg)
  );

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Height a bar must have, straight from the mapping rules.
  function automatic int model_height(input logic [15:0] x);
    int v;
    int p;
`ifdef FFT_SEQ_LOG_SCALE_EN
    if (x == 16'h0000) return 0;
    p = 0;
    v = int'(x);
    while (v > 1) begin
      v = v >> 1;
      p++;
    end
    v = 8 * p + (((int'(x) * 8) >> p) & 7);
`else
    p = 0;
    v = int'(x) >> 9;
`endif
    return (v > 100) ? 100 : v;
  endfunction

  logic [15:0] mem [128];
  logic [6:0]  exp_q[$];
  logic [6:0]  bar_exp_q[$];
  logic [6:0]  bar_addr_q[$];
  logic [6:0]  bar_seen [128];

  int   ends_in_frame = 0, starts_in_frame = 0, lr_cnt = 0, done_cnt = 0;
  int   nf_cnt = 0, frames_accepted = 0, fs_cycle = 0, start_total = 0;
  int   end_cnt = 0;
  bit   model_active = 0, accept_req = 0, nf_pending = 0, exp_dt = 0;
  bit   drawing = 0, stray_rd = 0, fs_on_done = 0, fs_arm = 0, fs_clear = 0, end_kick = 0;
  bit   rd_pend = 0, first_rd_seen = 0;
  logic [6:0] rd_pend_addr = '0, held_bar = '0, last_start_addr = '0, first_rd_addr = '0;

  // ---------------- magnitude buffer responder ----------------
  always @(posedge Clock) begin
    #1;
    RdData       = rd_pend ? mem[rd_pend_addr] : 16'h5A5A;
    rd_pend      = RdEn;
    rd_pend_addr = RdAddr;
  end

  // ---------------- spectrum writer model ----------------
  always @(posedge Clock) begin
    #1;
    End = 1'b0;
    if (fs_clear) begin FrameStart = 1'b0; fs_clear = 0; end
    if (fs_arm) begin FrameStart = 1'b1; fs_arm = 0; fs_clear = 1; end
    if (end_cnt > 0) begin
      end_cnt--;
      if (end_cnt == 0) begin
        End = 1'b1;
        ends_in_frame++;
        if (ends_in_frame == 2 * NB && fs_on_done) fs_arm = 1;
      end
    end
    if (Start && !Reset) end_cnt = END_DLY;
    if (stray_rd && RdEn) End = 1'b1;
    if (end_kick) begin End = 1'b1; end_kick = 0; end
  end

  // ---------------- compare process ----------------
  always @(negedge Clock) begin
    if (Reset) begin
      drawing = 0;
    end else begin
      check("active", Active, model_active);
      if (model_active) check("draw_top", DrawTop, exp_dt);
      if (RdEn) begin
        if (!first_rd_seen) begin first_rd_addr = RdAddr; first_rd_seen = 1; end
        drawing = 0;
        if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          logic [6:0] a;
          a = exp_q.pop_front();
          check("rd_addr", RdAddr, a);
          bar_exp_q.push_back(7'(model_height(mem[a])));
          bar_addr_q.push_back(a);
        end
      end
      if (Start) begin
        start_total++;
        if (bar_exp_q.size() == 0) check("start_unexpected", 1, 0);
        else begin
          logic [6:0] e;
          logic [6:0] ba;
          e  = bar_exp_q.pop_front();
          ba = bar_addr_q.pop_front();
          check("bar", Bar, e);
          bar_seen[ba] = Bar;
          held_bar = e;
          last_start_addr = ba;
          drawing = 1;
          starts_in_frame++;
          if (starts_in_frame == 1) check("start_latency", cyc - fs_cycle, 4);
        end
      end else if (drawing) begin
        check("bar_hold", Bar, held_bar);
      end
      if (LRChange) begin
        lr_cnt++;
        check("lrchange_after_L", ends_in_frame, NB);
      end
      if (NewFrame) begin
        nf_cnt++;
        check("newframe_expected", nf_pending, 1);
        nf_pending = 0;
      end
      if (FrameDone) begin
        done_cnt++;
        drawing = 0;
        check("framedone_after_R", ends_in_frame, 2 * NB);
        model_active = 0;
      end
      if (accept_req) begin
        model_active = 1;
        nf_pending = 1;
        accept_req = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic launch_frame(input bit dt);
    @(posedge Clock); #1;
    exp_q.delete(); bar_exp_q.delete(); bar_addr_q.delete();
    for (int i = 0; i < 2 * NB; i++) exp_q.push_back(7'(i));
    ends_in_frame = 0; starts_in_frame = 0; lr_cnt = 0; done_cnt = 0;
    first_rd_seen = 0; last_start_addr = '0;
    DrawTopEn = dt; exp_dt = dt;
    FrameStart = 1'b1; accept_req = 1; fs_cycle = cyc;
    frames_accepted++;
    @(posedge Clock); #1;
    FrameStart = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 20000) begin @(posedge Clock); n++; end
    #1;
    check({tag, "_done_timeout"}, (n < 20000), 1);
    repeat (6) @(posedge Clock);
    #1;
    check({tag, "_starts"}, starts_in_frame, 2 * NB);
    check({tag, "_ends"}, ends_in_frame, 2 * NB);
    check({tag, "_lrchange_cnt"}, lr_cnt, 1);
    check({tag, "_framedone_cnt"}, done_cnt, 1);
    check({tag, "_newframe_cnt"}, nf_cnt, frames_accepted);
    check({tag, "_first_addr"}, first_rd_addr, 7'h00);
    check({tag, "_idle_after"}, Active, 0);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rden"}, RdEn, 0);
    check({tag, "_rdaddr"}, RdAddr, 0);
    check({tag, "_start"}, Start, 0);
    check({tag, "_bar"}, Bar, 0);
    check({tag, "_drawtop"}, DrawTop, 0);
    check({tag, "_lrchange"}, LRChange, 0);
    check({tag, "_newframe"}, NewFrame, 0);
    check({tag, "_active"}, Active, 0);
    check({tag, "_framedone"}, FrameDone, 0);
    check({tag, "_state"}, StateDbg, S_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int st;
    repeat (3) @(posedge Clock);
    #1;
    check_all_zero("reset");
    Reset = 1'b0;

    // Stray End while idle must do nothing.
    @(posedge Clock); #1;
    st = start_total;
    end_kick = 1;
    repeat (4) @(posedge Clock);
    #1;
    check("idle_end_active", Active, 0);
    check("idle_end_state", StateDbg, S_IDLE);
    check("idle_end_nostart", start_total, st);

    // Frame A: clamped bars.
    for (int i = 0; i < 128; i++) mem[i] = 16'hC800;
    launch_frame(1'b0);
    finish_frame("frameA");
    check("frameA_bar_L0", bar_seen[0], 100);
    check("frameA_bar_R63", bar_seen[127], 100);

    // Frame B: stray End in READ, FrameStart in WAIT_END and with FrameDone.
    for (int i = 0; i < 128; i++) mem[i] = 16'h1400;
    stray_rd = 1; fs_on_done = 1;
    launch_frame(1'b1);
    n = 0;
    while (starts_in_frame < 3 && n < 1000) begin @(posedge Clock); n++; end
    #1;
    check("frameB_wait_end_timeout", (n < 1000), 1);
    FrameStart = 1'b1;
    @(posedge Clock); #1;
    FrameStart = 1'b0;
    finish_frame("frameB");
    stray_rd = 0; fs_on_done = 0;
`ifdef FFT_SEQ_LOG_SCALE_EN
    check("frameB_bar_L5", bar_seen[5], 98);
`else
    check("frameB_bar_L5", bar_seen[5], 10);
`endif

    // Frame C: mixed magnitudes including zero.
    for (int i = 0; i < 128; i++) mem[i] = 16'((i * 613) & 16'hFFFF);
    mem[0] = 16'h0000; mem[1] = 16'h0001; mem[2] = 16'h00A0;
    mem[3] = 16'hFFFF; mem[4] = 16'h1400; mem[5] = 16'h0200;
    mem[64] = 16'h0000; mem[127] = 16'hFFFF;
    launch_frame(1'b0);
    finish_frame("frameC");
    check("frameC_zero_L0", bar_seen[0], 0);
    check("frameC_zero_R0", bar_seen[64], 0);
    check("frameC_0001", bar_seen[1], 0);
    check("frameC_ffff", bar_seen[3], 100);
`ifdef FFT_SEQ_LOG_SCALE_EN
    check("frameC_00a0", bar_seen[2], 58);
    check("frameC_0200", bar_seen[5], 72);
`else
    check("frameC_00a0", bar_seen[2], 0);
    check("frameC_0200", bar_seen[5], 1);
`endif

    // Reset in WAIT_END of R bar 5.
    launch_frame(1'b1);
    n = 0;
    while (!(drawing && last_start_addr == 7'h45) && n < 5000) begin @(posedge Clock); n++; end
    #1;
    check("r5_reach_timeout", (n < 5000), 1);
    repeat (2) @(posedge Clock);
    #1;
    check("r5_in_wait_end", StateDbg, S_WAIT_END);
    Reset = 1'b1;
    end_cnt = 0;
    #1;
    check_all_zero("midreset");
    check("midreset_no_done", done_cnt, 0);
    exp_q.delete(); bar_exp_q.delete(); bar_addr_q.delete();
    model_active = 0; nf_pending = 0; accept_req = 0; rd_pend = 0;
    frames_accepted--;
    nf_cnt--;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    check("midreset_still_no_done", done_cnt, 0);

    // Frame D after reset restarts at L bar 0.
    for (int i = 0; i < 128; i++) mem[i] = 16'(i << 8);
    launch_frame(1'b0);
    finish_frame("frameD");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
